// File: rtl/clkdata_rx_if.sv
// Link bundle for clkdata_rx: peer clock/data inputs plus the recovered enables,
// deframed payload and link status.
interface clkdata_rx_if #(
    parameter int WORD_W = 16
);
    logic              rx_clk_3M;
    logic              rx_data;
    logic              enable_3M_rec;
    logic              enable_6M_rec;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              locked;
    logic              clock_lost;
    logic [7:0]        period_err_cnt;

    modport master (
        output rx_clk_3M, rx_data,
        input  enable_3M_rec, enable_6M_rec, data_out, data_valid,
               locked, clock_lost, period_err_cnt
    );

    modport slave (
        input  rx_clk_3M, rx_data,
        output enable_3M_rec, enable_6M_rec, data_out, data_valid,
               locked, clock_lost, period_err_cnt
    );
endinterface

// File: rtl/clkdata_rx.sv
// Receive end of the 3 MHz clock/data link: edge recovery, sync hunt, deframing and loss detect.
// Defining CLKDATA_RX_PERIOD_CHECK_EN builds the peer-period monitor behind period_err_cnt.
module clkdata_rx #(
    parameter int                WORD_W       = 16,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                MISS_LIMIT   = 3,
    parameter int                LOSS_TIMEOUT = 16
`ifdef CLKDATA_RX_PERIOD_CHECK_EN
    ,
    parameter int                PERIOD_TOL   = 1
`endif
) (
    input logic         CLK_24M,
    input logic         reset,
    clkdata_rx_if.slave link
);
    localparam int CNT_W  = $clog2(WORD_W > SYNC_W ? WORD_W : SYNC_W);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [MISS_W-1:0]   miss_cnt, miss_cnt_next;
    logic [2:0]          clk_sync;
    logic [1:0]          data_sync;
    logic [SYNC_W-1:0]   sreg;
    logic [SYNC_W-1:0]   window;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   data_out;
    logic [LOSS_W-1:0]   loss_cnt;
    logic                rise, fall, bit_in, lost_hit, deliver;
    logic                en3, en6, data_valid, clock_lost;

    assign rise     = clk_sync[1] & ~clk_sync[2];
    assign fall     = ~clk_sync[1] & clk_sync[2];
    assign bit_in   = data_sync[1];
    assign window   = {sreg[SYNC_W-2:0], bit_in};
    // A rise in the timeout cycle restarts the counter, so it suppresses the loss.
    assign lost_hit = ~rise && (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1));

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        miss_cnt_next = miss_cnt;
        deliver       = 1'b0;
        if (lost_hit) begin
            state_next    = HUNT;
            bit_cnt_next  = '0;
            miss_cnt_next = '0;
        end else if (rise) begin
            unique case (state)
                HUNT: begin
                    if (window == SYNC_PATTERN) begin
                        state_next    = RECEIVE;
                        bit_cnt_next  = '0;
                        miss_cnt_next = '0;
                    end
                end
                RECEIVE: begin
                    if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                        deliver      = 1'b1;
                        state_next   = CHECK;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (bit_cnt == CNT_W'(SYNC_W - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = RECEIVE;
                        if (window == SYNC_PATTERN) begin
                            miss_cnt_next = '0;
                        end else if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                            state_next    = HUNT;
                            miss_cnt_next = '0;
                        end else begin
                            miss_cnt_next = miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            miss_cnt <= miss_cnt_next;
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            en3        <= 1'b0;
            en6        <= 1'b0;
            sreg       <= '0;
            word       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            loss_cnt   <= '0;
            clock_lost <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], link.rx_clk_3M};
            data_sync  <= {data_sync[0], link.rx_data};
            en3        <= rise;
            en6        <= rise | fall;
            data_valid <= deliver;
            if (deliver) data_out <= {word[WORD_W-2:0], bit_in};
            // The word register shifts on every bit; framing alone decides when it is complete.
            if (rise) begin
                sreg <= window;
                word <= {word[WORD_W-2:0], bit_in};
            end
            if (rise) loss_cnt <= '0;
            else if (loss_cnt != LOSS_W'(LOSS_TIMEOUT)) loss_cnt <= loss_cnt + LOSS_W'(1);
            if (rise) clock_lost <= 1'b0;
            else if (lost_hit) clock_lost <= 1'b1;
        end
    end

`ifdef CLKDATA_RX_PERIOD_CHECK_EN
    localparam int PER_W   = LOSS_W + 1;
    localparam int NOMINAL = 8;

    logic             have_ref;
    logic [7:0]       err_cnt;
    logic [PER_W-1:0] period;
    logic             period_bad;

    // Cycles since the previous rise, counting the rise cycle itself.
    assign period     = {1'b0, loss_cnt} + PER_W'(1);
    assign period_bad = (period < PER_W'(NOMINAL - PERIOD_TOL)) ||
                        (period > PER_W'(NOMINAL + PERIOD_TOL));

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            have_ref <= 1'b0;
            err_cnt  <= '0;
        end else if (rise) begin
            have_ref <= 1'b1;
            if (have_ref && period_bad && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end else if (lost_hit) begin
            have_ref <= 1'b0;
        end
    end

    assign link.period_err_cnt = err_cnt;
`else
    assign link.period_err_cnt = '0;
`endif

    assign link.enable_3M_rec = en3;
    assign link.enable_6M_rec = en6;
    assign link.data_out      = data_out;
    assign link.data_valid    = data_valid;
    assign link.locked        = (state != HUNT);
    assign link.clock_lost    = clock_lost;
endmodule

// File: tb/tb_clkdata_rx.sv
// Self-checking bench for clkdata_rx: directed scenarios plus randomized framed streams
// checked against a bit-array framing model.
module tb_clkdata_rx;
    localparam int         WORD_W = 16;
    localparam logic [7:0] PAT    = 8'hA5;
    localparam int         MISS   = 3;
`ifdef CLKDATA_RX_PERIOD_CHECK_EN
    localparam int PCHK = 1;
`else
    localparam int PCHK = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clkdata_rx_if #(.WORD_W(WORD_W)) link();

    clkdata_rx #(
        .WORD_W(WORD_W), .SYNC_W(8), .SYNC_PATTERN(PAT),
        .MISS_LIMIT(MISS), .LOSS_TIMEOUT(16)
    ) dut (
        .CLK_24M(clk),
        .reset(rst_n),
        .link(link)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int q3[$];
    int q6[$];
    logic [WORD_W-1:0] obs[$];
    logic [WORD_W-1:0] exp_q[$];
    bit stim[$];
    int wide3 = 0, wide6 = 0, widedv = 0;
    int last_rise_cyc = 0, lost_cyc = -1;
    logic p3 = 1'b0, p6 = 1'b0, pdv = 1'b0, plost = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (link.enable_3M_rec) begin
            q3.push_back(cyc);
            last_rise_cyc = cyc;
            if (p3) wide3++;
        end
        if (link.enable_6M_rec) begin
            q6.push_back(cyc);
            if (p6) wide6++;
        end
        if (link.data_valid) begin
            obs.push_back(link.data_out);
            if (pdv) widedv++;
        end
        if (link.clock_lost && !plost) lost_cyc = cyc;
        p3    = link.enable_3M_rec;
        p6    = link.enable_6M_rec;
        pdv   = link.data_valid;
        plost = link.clock_lost;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time budget exhausted, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One peer bit: clock low for lo cycles (data changes here), then high for hi cycles.
    task automatic peer_cycle(input logic b, input int lo, input int hi);
        @(negedge clk);
        link.rx_clk_3M = 1'b0;
        link.rx_data   = b;
        repeat (lo) @(negedge clk);
        link.rx_clk_3M = 1'b1;
        repeat (hi - 1) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) peer_cycle(v[i], 4, 4);
    endtask

    task automatic do_reset();
        link.rx_clk_3M = 1'b0;
        link.rx_data   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] win_at(input int j);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[7-i] = stim[j-7+i];
        return w;
    endfunction

    function automatic logic [15:0] word_at(input int j);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = stim[j+i];
        return w;
    endfunction

    // Framing rules on the whole bit array: find a sync, take 16 payload bits, then judge
    // the following 8 bits as the next sync; MISS misses in a row resume the search.
    task automatic build_expected();
        int n, k, s, misses;
        bit hunting, done;
        n = stim.size();
        s = 7;
        done = 0;
        exp_q.delete();
        while (!done) begin
            k = -1;
            for (int j = s; j < n && k < 0; j++) if (win_at(j) == PAT) k = j;
            if (k < 0) done = 1;
            else begin
                misses = 0;
                hunting = 0;
                while (!done && !hunting) begin
                    if (k + 16 >= n) done = 1;
                    else begin
                        exp_q.push_back(word_at(k + 1));
                        if (k + 24 >= n) done = 1;
                        else if (win_at(k + 24) == PAT) begin
                            misses = 0;
                            k += 24;
                        end else begin
                            misses++;
                            if (misses == MISS) begin
                                hunting = 1;
                                s = k + 25;
                            end else k += 24;
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        link.rx_clk_3M = 1'b0;
        link.rx_data   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({link.enable_3M_rec, link.enable_6M_rec, link.data_valid, link.locked,
             link.clock_lost, link.period_err_cnt} !== 13'h0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0", {link.enable_3M_rec, link.enable_6M_rec,
                     link.data_valid, link.locked, link.clock_lost, link.period_err_cnt});
        end
        checks++;
        if (link.data_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_data_out: got %h required 0000", link.data_out);
        end
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (link.clock_lost !== 1'b0) begin
            failures++;
            $display("FAIL idle_lost_early: got %b required 0 at cycle 15", link.clock_lost);
        end
        @(negedge clk);
        checks++;
        if (link.clock_lost !== 1'b1) begin
            failures++;
            $display("FAIL idle_lost: got %b required 1 at cycle 16", link.clock_lost);
        end
        checks++;
        if (link.locked !== 1'b0) begin
            failures++;
            $display("FAIL idle_locked: got %b required 0", link.locked);
        end
    endtask

    task automatic test_enables();
        int lat, bad3, bad6;
        do_reset();
        @(negedge clk);
        link.rx_clk_3M = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (link.enable_3M_rec) lat = k;
        end
        checks++;
        if (lat < 3 || lat > 4) begin
            failures++;
            $display("FAIL enable_latency: got %0d cycles required 3..4", lat);
        end
        settle(1);
        q3.delete();
        q6.delete();
        wide3 = 0;
        wide6 = 0;
        repeat (12) peer_cycle(1'b0, 4, 4);
        settle(2);
        bad3 = 0;
        bad6 = 0;
        for (int i = 1; i < q3.size(); i++) if (q3[i] - q3[i-1] != 8) bad3++;
        for (int i = 1; i < q6.size(); i++) if (q6[i] - q6[i-1] != 4) bad6++;
        checks++;
        if (q3.size() != 12 || bad3 != 0) begin
            failures++;
            $display("FAIL enable_3M: got %0d pulses, %0d bad gaps; required 12 pulses every 8", q3.size(), bad3);
        end
        checks++;
        if (q6.size() != 24 || bad6 != 0) begin
            failures++;
            $display("FAIL enable_6M: got %0d pulses, %0d bad gaps; required 24 pulses every 4", q6.size(), bad6);
        end
        checks++;
        if (wide3 != 0 || wide6 != 0) begin
            failures++;
            $display("FAIL enable_width: got %0d/%0d multi-cycle pulses required 0/0", wide3, wide6);
        end
        checks++;
        if (link.clock_lost !== 1'b0) begin
            failures++;
            $display("FAIL enable_lost_clear: got %b required 0", link.clock_lost);
        end
    endtask

    task automatic test_lock_payload();
        do_reset();
        obs.delete();
        widedv = 0;
        send_bits({24'h0, PAT} >> 1, 7);
        checks++;
        if (link.locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_early: got %b required 0 after 7 sync bits", link.locked);
        end
        send_bits(32'h1, 1);
        checks++;
        if (link.locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_rise: got %b required 1 after 8th sync bit", link.locked);
        end
        send_bits(32'h1234, 16);
        send_bits({24'h0, PAT}, 8);
        send_bits(32'hBEEF, 16);
        settle(2);
        checks++;
        if (obs.size() != 2 || obs[0] !== 16'h1234 || obs[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL payload_words: got %0d words first %h last %h required 2 words 1234 beef",
                     obs.size(), obs.size() > 0 ? obs[0] : 16'hxxxx, obs.size() > 0 ? obs[$] : 16'hxxxx);
        end
        checks++;
        if (widedv != 0 || link.data_out !== 16'hBEEF) begin
            failures++;
            $display("FAIL payload_hold: got width-faults %0d data_out %h required 0 and beef", widedv, link.data_out);
        end
    endtask

    task automatic test_sync_misses();
        do_reset();
        obs.delete();
        send_bits({24'h0, PAT}, 8);
        send_bits(32'h1357, 16);
        send_bits(32'h00, 8);
        send_bits(32'h2468, 16);
        send_bits(32'h00, 8);
        checks++;
        if (link.locked !== 1'b1) begin
            failures++;
            $display("FAIL miss2_locked: got %b required 1", link.locked);
        end
        send_bits(32'hC3C3, 16);
        send_bits(32'h00, 8);
        checks++;
        if (link.locked !== 1'b0) begin
            failures++;
            $display("FAIL miss3_unlock: got %b required 0", link.locked);
        end
        send_bits({24'h0, PAT}, 8);
        checks++;
        if (link.locked !== 1'b1) begin
            failures++;
            $display("FAIL relock: got %b required 1", link.locked);
        end
        send_bits(32'h5AF0, 16);
        settle(2);
        checks++;
        if (obs.size() != 4 || obs[0] !== 16'h1357 || obs[1] !== 16'h2468 ||
            obs[2] !== 16'hC3C3 || obs[3] !== 16'h5AF0) begin
            failures++;
            $display("FAIL miss_words: got %0d words last %h required 4 words 1357 2468 c3c3 5af0",
                     obs.size(), obs.size() > 0 ? obs[$] : 16'hxxxx);
        end
    endtask

    task automatic test_clock_loss();
        int n;
        do_reset();
        obs.delete();
        send_bits({24'h0, PAT}, 8);
        send_bits(32'h0, 5);
        lost_cyc = -1;
        n = 0;
        while (n < 40 && link.clock_lost !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (link.clock_lost !== 1'b1 || lost_cyc - last_rise_cyc != 16) begin
            failures++;
            $display("FAIL loss_timing: got lost=%b after %0d cycles required 1 after 16",
                     link.clock_lost, lost_cyc - last_rise_cyc);
        end
        checks++;
        if (link.locked !== 1'b0 || obs.size() != 0) begin
            failures++;
            $display("FAIL loss_discard: got locked=%b words=%0d required 0 and 0", link.locked, obs.size());
        end
        peer_cycle(1'b0, 4, 4);
        checks++;
        if (link.clock_lost !== 1'b0 || link.locked !== 1'b0) begin
            failures++;
            $display("FAIL loss_restart: got lost=%b locked=%b required 0 and 0", link.clock_lost, link.locked);
        end
        send_bits({24'h0, PAT}, 8);
        send_bits(32'h9C3A, 16);
        settle(2);
        checks++;
        if (obs.size() != 1 || obs[0] !== 16'h9C3A || link.locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_relock: got %0d words locked=%b required 1 word 9c3a locked=1", obs.size(), link.locked);
        end
    endtask

    task automatic test_period_check();
        int lo_seq[9] = '{4, 4, 4, 4, 4, 7, 2, 5, 4};
        do_reset();
        for (int i = 0; i < 6; i++) peer_cycle(1'b0, lo_seq[i], 4);
        checks++;
        if (link.period_err_cnt !== 8'(PCHK)) begin
            failures++;
            $display("FAIL period_mid: got %0d required %0d", link.period_err_cnt, PCHK);
        end
        for (int i = 6; i < 9; i++) peer_cycle(1'b0, lo_seq[i], 4);
        settle(1);
        checks++;
        if (link.period_err_cnt !== 8'(2 * PCHK)) begin
            failures++;
            $display("FAIL period_final: got %0d required %0d", link.period_err_cnt, 2 * PCHK);
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            stim.delete();
            obs.delete();
            q3.delete();
            repeat (20) stim.push_back(1'($urandom_range(1, 0)));
            for (int f = 0; f < 6; f++) begin
                logic [7:0]  s;
                logic [15:0] p;
                s = ($urandom_range(1, 0) == 0) ? PAT : 8'($urandom);
                p = 16'($urandom);
                for (int i = 7; i >= 0; i--) stim.push_back(s[i]);
                for (int i = 15; i >= 0; i--) stim.push_back(p[i]);
            end
            for (int i = 0; i < stim.size(); i++)
                peer_cycle(stim[i], int'($urandom_range(5, 3)), int'($urandom_range(5, 3)));
            settle(3);
            build_expected();
            checks++;
            if (q3.size() != stim.size()) begin
                failures++;
                $display("FAIL rand_edges[%0d]: got %0d pulses required %0d", it, q3.size(), stim.size());
            end
            checks++;
            if (obs.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_count[%0d]: got %0d words required %0d", it, obs.size(), exp_q.size());
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_word[%0d][%0d]: got %h required %h", it, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        link.rx_clk_3M = 1'b0;
        link.rx_data   = 1'b0;
        test_reset();
        test_enables();
        test_lock_payload();
        test_sync_misses();
        test_clock_loss();
        test_period_check();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clkdata_rx.md
Name: clkdata_rx

Overview:
- Receive end of the 3 MHz clock/data link. Takes a peer's generated 3M clock and serial data line, both asynchronous to local CLK_24M.
- Synchronises both lines, recovers 3M/6M enable pulses from the peer clock edges, and hunts for a sync word.
- Deserialises framed payload words, reports lock status, and detects loss of the peer clock.

Parameters:
- WORD_W, 16, payload bits per frame.
- SYNC_W, 8, sync word bits per frame.
- SYNC_PATTERN, 8'hA5, sync word value, MSB first.
- MISS_LIMIT, 3, consecutive bad sync words that force a return to HUNT.
- LOSS_TIMEOUT, 16, CLK_24M cycles without a peer rising edge before the clock is declared lost.
- PERIOD_TOL, 1, allowed deviation in CLK_24M cycles from the nominal 8-cycle period (optional feature only).

Ports:
- CLK_24M  in  1  local 24 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- rx_clk_3M  in  1  peer 3M clock, asynchronous to CLK_24M.
- rx_data  in  1  peer serial data. Peer updates it while rx_clk_3M is low; it is stable at the peer rising edge.
- enable_3M_rec  out  1  one-cycle pulse per detected peer rising edge.
- enable_6M_rec  out  1  one-cycle pulse per detected peer rising or falling edge.
- data_out  out  WORD_W  last complete payload word, MSB first on the wire.
- data_valid  out  1  one-cycle pulse when data_out updates.
- locked  out  1  high in states RECEIVE and CHECK.
- clock_lost  out  1  peer clock absent.
- period_err_cnt  out  8  saturating count of out-of-tolerance periods (optional feature).

Behaviour:
- Reset: one clock (CLK_24M) with asynchronous active-low reset. On reset all outputs are 0, the FSM is in HUNT, and the synchronisers are cleared.
- Synchronisers:
  - Two-flop synchroniser on rx_clk_3M and on rx_data, plus one history flop on the clock path.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Data bit captured from the data-sync stage 2 in the cycle rise is true.
- Recovered enables:
  - enable_3M_rec = rise, registered.
  - enable_6M_rec = rise | fall, registered.
  - Latency from the peer edge is 3-4 CLK_24M cycles.
- Shift register: SYNC_W-bit window (sreg). Each captured bit is shifted in at the LSB; the last SYNC_W bits are compared against SYNC_PATTERN.
- FSM HUNT: shift every bit.
  - On window == SYNC_PATTERN: go to RECEIVE, clear the bit counter, clear the miss counter.
- FSM RECEIVE: collect WORD_W bits.
  - After the WORD_W-th bit: data_out <= word, data_valid pulses on the next cycle, go to CHECK.
- FSM CHECK: collect SYNC_W bits.
  - If the sync matches: clear the miss counter, go to RECEIVE.
  - If it does not match: increment the miss counter. Reaching MISS_LIMIT goes to HUNT (locked drops). Otherwise go to RECEIVE anyway; the frame is still delivered.
- Clock loss:
  - The cycle counter resets on each rise and saturates at LOSS_TIMEOUT.
  - When it reaches LOSS_TIMEOUT: clock_lost = 1, FSM forced to HUNT, bit counter and miss counter cleared, partial word discarded (no data_valid).
  - clock_lost clears in the cycle after the next rise.
  - While clock_lost is set, enable pulses still follow any edges.
- Simultaneous events:
  - Timeout and rise in the same cycle: rise wins. The counter clears and there is no loss.
  - data_valid is never asserted in a cycle in which the FSM is forced to HUNT.
- No back-pressure. data_out holds until the next valid word.

Optional Feature:
- Macro: CLKDATA_RX_PERIOD_CHECK_EN.
- Defined:
  - The count of CLK_24M cycles between consecutive rises is compared with 8±PERIOD_TOL.
  - Each out-of-range period increments period_err_cnt, saturating at 255.
  - The first period after reset or after clock_lost is not checked.
- Undefined: period_err_cnt is tied to 0 and no period logic is built.

Test Plan:
- Reset / idle: reset low, then high with rx_clk_3M static 0 -> all outputs 0; clock_lost = 1 after 16 cycles.
- Enable recovery: ideal 8-cycle peer clock -> enable_3M_rec every 8 cycles, enable_6M_rec every 4 cycles, each one cycle wide.
- Lock and payload: stream 0xA5, 0x1234, 0xA5, 0xBEEF ->
  - locked rises after the 8th sync bit;
  - data_valid pulses twice with data_out 0x1234 then 0xBEEF.
- Sync misses: after lock, corrupt 3 consecutive sync words to 0x00 ->
  - frames 1-2 delivered with locked = 1;
  - after the 3rd miss locked = 0;
  - a subsequent 0xA5 relocks.
- Clock loss mid-word: stop rx_clk_3M after 5 payload bits ->
  - clock_lost = 1 16 cycles after the last rise, locked = 0, no data_valid;
  - when the clock restarts, clock_lost clears and HUNT resumes.
- Period check (macro defined): inject periods of 8, 8, 11, 6, 9 ->
  - period_err_cnt = 2;
  - with the macro undefined it stays 0.
